// File: rtl/conv_window_gen.sv
// conv_window_gen: K x K sliding-window generator over a raster multi-channel pixel stream; define CONV_WIN_1X1_EN to enable 1x1 mode
module conv_window_gen #(
    parameter int DATA_WIDTH      = 16,
    parameter int INPUT_DIM       = 4,
    parameter int CONV_KERNEL_DIM = 3,
    parameter int DIM_WIDTH       = 10,
    parameter int MAX_COLS        = 416
) (
    input  logic                                                          clk,
    input  logic                                                          reset,
    input  logic [DIM_WIDTH-1:0]                                          max_cols_in,
    input  logic [DIM_WIDTH-1:0]                                          max_rows_in,
    input  logic [DIM_WIDTH-1:0]                                          conv_size_in,
    input  logic [INPUT_DIM*DATA_WIDTH-1:0]                               pix_in,
    input  logic                                                          pix_valid_in,
    output logic [CONV_KERNEL_DIM*CONV_KERNEL_DIM*INPUT_DIM*DATA_WIDTH-1:0] window_bus_out,
    output logic [INPUT_DIM-1:0]                                          window_bus_valid_out,
    output logic                                                          frame_done_out
);
    localparam int K   = CONV_KERNEL_DIM;
    localparam int MID = K / 2;
    localparam int AW  = $clog2(MAX_COLS);
    logic [DIM_WIDTH-1:0] col_cnt, row_cnt, cols_q, rows_q, eff_cols, eff_rows;
    logic                 first, last_col, last_row, emit, valid_q;
    logic [AW-1:0]        col_idx;
    logic [DATA_WIDTH-1:0] lb     [INPUT_DIM][K-1][MAX_COLS];
    logic [DATA_WIDTH-1:0] win    [INPUT_DIM][K][K];
    logic [DATA_WIDTH-1:0] newcol [INPUT_DIM][K];
`ifdef CONV_WIN_1X1_EN
    logic size1, size1_q;
`else
    logic unused_size;
    assign unused_size = ^conv_size_in;
`endif

    // frame geometry comes straight from the inputs on the first pixel, from the latched copy afterwards
    always_comb begin
        first    = col_cnt == '0 && row_cnt == '0;
        eff_cols = first ? max_cols_in : cols_q;
        eff_rows = first ? max_rows_in : rows_q;
        last_col = col_cnt == eff_cols - DIM_WIDTH'(1);
        last_row = row_cnt == eff_rows - DIM_WIDTH'(1);
        col_idx  = col_cnt[AW-1:0];
`ifdef CONV_WIN_1X1_EN
        size1    = first ? conv_size_in == DIM_WIDTH'(1) : size1_q;
        emit     = size1 || (row_cnt >= DIM_WIDTH'(K-1) && col_cnt >= DIM_WIDTH'(K-1));
`else
        emit     = row_cnt >= DIM_WIDTH'(K-1) && col_cnt >= DIM_WIDTH'(K-1);
`endif
    end

    // incoming column: oldest buffered row at the top, live pixel at the bottom
    always_comb begin
        for (int i = 0; i < INPUT_DIM; i++) begin
            newcol[i][K-1] = pix_in[i*DATA_WIDTH +: DATA_WIDTH];
            for (int j = 0; j < K-1; j++) newcol[i][j] = lb[i][K-2-j][col_idx];
        end
    end

    // raster counters, per-frame config latch and registered strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt        <= '0;
            row_cnt        <= '0;
            cols_q         <= '0;
            rows_q         <= '0;
            valid_q        <= 1'b0;
            frame_done_out <= 1'b0;
`ifdef CONV_WIN_1X1_EN
            size1_q        <= 1'b0;
`endif
        end else begin
            valid_q        <= pix_valid_in && emit;
            frame_done_out <= pix_valid_in && last_col && last_row;
            if (pix_valid_in) begin
                cols_q  <= eff_cols;
                rows_q  <= eff_rows;
`ifdef CONV_WIN_1X1_EN
                size1_q <= size1;
`endif
                col_cnt <= last_col ? '0 : col_cnt + DIM_WIDTH'(1);
                row_cnt <= last_col ? (last_row ? '0 : row_cnt + DIM_WIDTH'(1)) : row_cnt;
            end
        end
    end

    // line buffers cascade the previous K-1 rows; contents survive reset
    always_ff @(posedge clk) begin
        if (pix_valid_in && !reset) begin
            for (int i = 0; i < INPUT_DIM; i++) begin
                lb[i][0][col_idx] <= pix_in[i*DATA_WIDTH +: DATA_WIDTH];
                for (int j = 1; j < K-1; j++) lb[i][j][col_idx] <= lb[i][j-1][col_idx];
            end
        end
    end

    // window array shifts left each accepted pixel and doubles as the output register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < INPUT_DIM; i++)
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++) win[i][r][c] <= '0;
        end else if (pix_valid_in) begin
            for (int i = 0; i < INPUT_DIM; i++)
                for (int r = 0; r < K; r++) begin
`ifdef CONV_WIN_1X1_EN
                    if (size1) begin
                        for (int c = 0; c < K; c++) win[i][r][c] <= (r == MID && c == MID) ? newcol[i][K-1] : '0;
                    end else
`endif
                    begin
                        for (int c = 0; c < K-1; c++) win[i][r][c] <= win[i][r][c+1];
                        win[i][r][K-1] <= newcol[i][r];
                    end
                end
        end
    end

    // pack channel-major, then row-major within each channel
    always_comb begin
        window_bus_out = '0;
        for (int i = 0; i < INPUT_DIM; i++)
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    window_bus_out[((i*K + r)*K + c)*DATA_WIDTH +: DATA_WIDTH] = win[i][r][c];
    end

    assign window_bus_valid_out = {INPUT_DIM{valid_q}};
endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Sliding-window generator that sits directly upstream of the per-output-channel convolution stage. It converts a raster-order pixel stream of INPUT_DIM parallel channels into K×K windows per channel, using line buffers and column shift registers. It drives the window bus and per-channel window valids in exactly the packing that stage consumes. Data words are opaque (half-float bit patterns); no arithmetic is applied to pixel data.

## Interface
- DATA_WIDTH, 16, pixel word width (global params header)
- INPUT_DIM, 4, parallel input channels (global params header)
- CONV_KERNEL_DIM, 3, window edge K (global params header)
- DIM_WIDTH, 10, width of dimension fields (global params header)
- MAX_COLS, 416, line-buffer depth; largest supported frame width
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- max_cols_in  in  DIM_WIDTH  frame width C in pixels (1..MAX_COLS)
- max_rows_in  in  DIM_WIDTH  frame height R in pixels (≥1)
- conv_size_in  in  DIM_WIDTH  kernel size: 3 or 1
- pix_in  in  INPUT_DIM*DATA_WIDTH  one pixel per channel; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- pix_valid_in  in  1  pix_in valid; no backpressure, gaps allowed
- window_bus_out  out  K*K*INPUT_DIM*DATA_WIDTH  channel i at [i*K*K*DATA_WIDTH +: K*K*DATA_WIDTH]; within it element (kr,kc) at [(kr*K+kc)*DATA_WIDTH +: DATA_WIDTH]; kr=0 oldest row, kc=0 leftmost column
- window_bus_valid_out  out  INPUT_DIM  all bits identical; one-cycle pulse per window
- frame_done_out  out  1  one-cycle pulse after the last pixel of a frame

## Operation
- Counters col_cnt (0..C-1) and row_cnt (0..R-1) advance only on pix_valid_in; col wraps to 0 and row increments at C-1; at (R-1, C-1) both return to 0.
- C, R and conv_size are latched from the inputs on the first accepted pixel of a frame, i.e. when col_cnt=row_cnt=0. Input changes mid-frame are ignored.
- Per channel: K-1 line buffers of MAX_COLS words, read and written at col_cnt, cascade the previous K-1 rows. A K×K register array shifts left by one column per accepted pixel. New column = {line_buf[K-2][col], …, line_buf[0][col], pix}, with top-to-bottom order = kr 0..K-1.
- 3×3 mode: a window is emitted for an accepted pixel iff row_cnt ≥ 2 and col_cnt ≥ 2 (valid convolution, no padding). Output count per frame = (R-2)*(C-2), or 0 if R<3 or C<3.
- 1×1 mode: every accepted pixel emits a window; element (1,1) = pixel, all other elements = 0. Count = R*C.
- Columns from the previous row never leak into a window, because windows are suppressed for col_cnt < 2.
- frame_done_out pulses for every frame, including degenerate frames with no windows.
- conv_size_in values other than 1 and 3 behave as 3.

## Timing
- Latency: window_bus_valid_out asserts exactly 1 cycle after the pix_valid_in cycle that completes the window. window_bus_out is registered and holds its value until the next accepted pixel.
- frame_done_out asserts in the same cycle as the final window's valid (1 cycle after the last pixel).
- Back-to-back pixels: one window per cycle sustained. There is no stall path.
- Reset values: window_bus_valid_out=0, frame_done_out=0, window_bus_out=0, counters=0, latched config C=R=0, size=3. Line-buffer RAM is not cleared.
- Reset mid-frame: all outputs are 0 on the next cycle. The next accepted pixel is treated as (0,0) of a new frame. Stale line-buffer data is never emitted, because rows 0 and 1 refill before any window is produced.
- A pix_valid_in coincident with reset is dropped.

## Configuration
- CONV_WIN_1X1_EN: when defined, conv_size_in=1 selects 1×1 mode as described above.
- When not defined, conv_size_in is ignored, the block is always 3×3, and no 1×1 zeroing logic is synthesised.

## Test plan
- C=4, R=4, 3×3, channel 0 pixel = r*4+c, channel i = that value + 0x100*i, continuous valid → 4 windows. First window (after pixel 10) in ch0 = 0,1,2 / 4,5,6 / 8,9,10. Last window = 5,6,7 / 9,10,11 / 13,14,15. frame_done_out is coincident with the last window.
- Same frame with pix_valid_in toggling 1/0 → identical window contents. Each valid is 1 cycle after its completing pixel. Outputs hold during gaps.
- C=2, R=5, 3×3 → zero windows; a single frame_done_out pulse 1 cycle after the 10th pixel.
- With CONV_WIN_1X1_EN defined: C=3, R=2, size 1, pixel value 7 → 6 windows. Each has element (1,1)=7 and the other 8 elements = 0.
- Reset asserted after 6 pixels of a 4×4 frame, then a full fresh 4×4 frame → exactly 4 correct windows. No window contains pre-reset data.
- Two consecutive frames, 4×4 then 5×3 (max_cols_in changed only between frames) → 4 windows then 3 windows, each with correct contents.
